multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback for a
// single-ALU datapath, handshakes with instruction/data memory, counts retirements.
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ALUAsrc,
  output logic [1:0]       ALUBsrc,
  output logic [3:0]       ALUctr,
  output logic [2:0]       Branch,
  output logic             MemtoReg,
  output logic             reg_we,
  output logic             pc_we,
  output logic [CNT_W-1:0] instret,
  output logic             illegal,
  output logic             bus_err
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;

  logic       asrc_q, m2r_q, load_q, store_q, wr_q;
  logic [1:0] bsrc_q;
  logic [3:0] ctr_q;
  logic [2:0] br_q;

  logic [4:0] op5;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       d_asrc, d_load, d_store, d_wr, d_ill, d_ebreak;
  logic [1:0] d_bsrc;
  logic [3:0] d_ctr;
  logic [2:0] d_br;
  logic       unused_instr;

  assign op5          = instr[6:2];
  assign funct3       = instr[14:12];
  assign funct7b5     = instr[30];
  assign unused_instr = ^{instr[31], instr[29:21], instr[19:15], instr[1:0]};

  // slt and sltu share the comparator; the top bit selects unsigned / sub / sra
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = {alt, 3'b000};
      3'b011:  alu_op = 4'b1010;
      3'b101:  alu_op = {alt, 3'b101};
      default: alu_op = {1'b0, f3};
    endcase
  endfunction

  always_comb begin
    d_asrc   = 1'b0;
    d_bsrc   = 2'b00;
    d_ctr    = 4'b0000;
    d_br     = 3'b000;
    d_load   = 1'b0;
    d_store  = 1'b0;
    d_wr     = 1'b0;
    d_ill    = 1'b0;
    d_ebreak = 1'b0;
    case (op5)
      5'b01100: begin d_ctr = alu_op(funct3, funct7b5); d_wr = 1'b1; end
      // only srai honours bit 30 on I-type; elsewhere it is immediate data
      5'b00100: begin
        d_bsrc = 2'b01; d_ctr = alu_op(funct3, funct7b5 & (funct3 == 3'b101)); d_wr = 1'b1;
      end
      5'b01101: begin d_bsrc = 2'b01; d_ctr = 4'b0011; d_wr = 1'b1; end
      5'b00101: begin d_asrc = 1'b1; d_bsrc = 2'b01; d_wr = 1'b1; end
      5'b11011: begin d_asrc = 1'b1; d_bsrc = 2'b10; d_br = 3'b001; d_wr = 1'b1; end
      5'b11001: begin d_asrc = 1'b1; d_bsrc = 2'b10; d_br = 3'b010; d_wr = 1'b1; end
      5'b11000: begin
        d_ctr = funct3[1] ? 4'b1010 : 4'b0010;
        d_br  = {1'b1, funct3[2], funct3[0]};
        d_ill = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      5'b00000: begin
        d_bsrc = 2'b01; d_load = 1'b1; d_wr = 1'b1;
        d_ill  = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      end
      5'b01000: begin
        d_bsrc = 2'b01; d_store = 1'b1;
        d_ill  = (funct3[2] == 1'b1) || (funct3 == 3'b011);
      end
      5'b11100: d_ebreak = instr[20];
      default:  d_ill = 1'b1;
    endcase
    if (instr[11:7] == 5'd0) d_wr = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) state_d = S_DECODE;
        else if (wait_q == 8'(TIMEOUT)) begin bus_err_d = 1'b1; state_d = S_HALT; end
        else wait_d = wait_q + 8'd1;
      end
      S_DECODE: begin
        if (d_ill) begin illegal_d = 1'b1; state_d = S_HALT; end
        else if (d_ebreak) state_d = S_HALT;
        else state_d = S_EXEC;
      end
      S_EXEC: state_d = (load_q || store_q) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) state_d = S_WB;
        else if (wait_q == 8'(TIMEOUT)) begin bus_err_d = 1'b1; state_d = S_HALT; end
        else wait_d = wait_q + 8'd1;
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
    if (state_d != state_q) wait_d = '0;
  end

  // controls latch once per instruction and stay put through HALT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asrc_q <= 1'b0; bsrc_q <= 2'b00; ctr_q <= 4'b0000; br_q <= 3'b000;
      m2r_q <= 1'b0; load_q <= 1'b0; store_q <= 1'b0; wr_q <= 1'b0;
    end else if (state_q == S_DECODE && !d_ill && !d_ebreak) begin
      asrc_q <= d_asrc; bsrc_q <= d_bsrc; ctr_q <= d_ctr; br_q <= d_br;
      m2r_q <= d_load; load_q <= d_load; store_q <= d_store; wr_q <= d_wr;
    end
  end

  // strobes are gated by rst so an in-flight request drops the moment reset asserts
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    pc_we    = 1'b0;
    reg_we   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin imem_req = 1'b1; ir_we = imem_ack; end
        S_MEM:   begin dmem_req = 1'b1; dmem_we = store_q; end
        S_WB:    begin pc_we = 1'b1; reg_we = wr_q; end
        default: ;
      endcase
    end
  end

  assign ALUAsrc  = asrc_q;
  assign ALUBsrc  = bsrc_q;
  assign ALUctr   = ctr_q;
  assign Branch   = br_q;
  assign MemtoReg = m2r_q;
  assign instret  = instret_q;
  assign illegal  = illegal_q;
  assign bus_err  = bus_err_q;

endmodule
